// File: rtl/pam_4_prbs_checker.sv
// Self-synchronising PRBS checker for a decoded PAM-4 symbol stream (2 PRBS bits per symbol).
// Seeds a local LFSR from the received bits, verifies it, then counts bit errors and compared bits.
module pam_4_prbs_checker #(
    parameter int PRBS_ORDER  = 7,
    parameter int LOCK_SYMS   = 16,
    parameter int WINDOW_SYMS = 64,
    parameter int LOSS_THRESH = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       symbol_in,
    input  logic             symbol_in_valid,
    input  logic             clear_counts,
    output logic             locked,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] bit_count,
    output logic             symbol_error
);

    localparam int TAP       = (PRBS_ORDER == 31) ? 28 : 6;
    localparam int SEEK_SYMS = (PRBS_ORDER + 1) / 2;
    localparam int SEEK_W    = $clog2(SEEK_SYMS + 1);
    localparam int CLEAN_W   = $clog2(LOCK_SYMS + 1);
    localparam int WIN_W     = $clog2(WINDOW_SYMS + 1);
    localparam int WERR_W    = $clog2(LOSS_THRESH + 3);

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    function automatic logic [PRBS_ORDER-1:0] lfsr_step(input logic [PRBS_ORDER-1:0] s);
        lfsr_step = {s[PRBS_ORDER-2:0], s[PRBS_ORDER-1] ^ s[TAP-1]};
    endfunction

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        popcount2 = {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{(CNT_W - 1){1'b0}}, inc};
        sat_add = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    state_e                  state_q, state_d;
    logic [PRBS_ORDER-1:0]   lfsr_q, lfsr_d;
    logic [SEEK_W-1:0]       seek_cnt_q, seek_cnt_d;
    logic [CLEAN_W-1:0]      clean_cnt_q, clean_cnt_d;
    logic [WIN_W-1:0]        win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]       win_err_q, win_err_d;
    logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    locked_q, locked_d;
    logic                    sym_err_q, sym_err_d;

    logic [PRBS_ORDER-1:0]   step1_s;
    logic [PRBS_ORDER-1:0]   step2_s;
    logic [PRBS_ORDER-1:0]   seek_shift_s;
    logic [1:0]              pred_s;
    logic [1:0]              e_s;
    logic [CLEAN_W-1:0]      clean_inc_s;
    logic [WIN_W-1:0]        win_inc_s;
    logic [WERR_W-1:0]       win_err_sum_s;

    // The first LFSR step predicts the earlier bit (symbol bit 1), the second the later bit.
    assign step1_s       = lfsr_step(lfsr_q);
    assign step2_s       = lfsr_step(step1_s);
    assign pred_s        = {step1_s[0], step2_s[0]};
    assign seek_shift_s  = {lfsr_q[PRBS_ORDER-3:0], symbol_in};
    assign e_s           = popcount2(pred_s ^ symbol_in);
    assign clean_inc_s   = clean_cnt_q + CLEAN_W'(1);
    assign win_inc_s     = win_cnt_q + WIN_W'(1);
    assign win_err_sum_s = win_err_q + WERR_W'(e_s);

    // Next-state logic: acquisition FSM, LFSR, loss-of-lock window and BER counters.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        seek_cnt_d  = seek_cnt_q;
        clean_cnt_d = clean_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sym_err_d   = 1'b0;

        if (symbol_in_valid) begin
            case (state_q)
                ST_SEEK: begin
                    lfsr_d = seek_shift_s;
                    if (seek_cnt_q == SEEK_W'(SEEK_SYMS - 1)) begin
                        seek_cnt_d = '0;
                        // An all-zero seed is the LFSR's lock-up state, so keep seeking.
                        if (seek_shift_s == '0) begin
                            state_d = ST_SEEK;
                        end else begin
                            state_d     = ST_VERIFY;
                            clean_cnt_d = '0;
                        end
                    end else begin
                        seek_cnt_d = seek_cnt_q + SEEK_W'(1);
                    end
                end
                ST_VERIFY: begin
                    lfsr_d = step2_s;
                    if (e_s != 2'd0) begin
                        state_d    = ST_SEEK;
                        seek_cnt_d = '0;
                    end else if (clean_inc_s == CLEAN_W'(LOCK_SYMS)) begin
                        state_d   = ST_LOCKED;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        clean_cnt_d = clean_inc_s;
                    end
                end
                ST_LOCKED: begin
                    // Free-running: received errors never feed back into the LFSR.
                    lfsr_d    = step2_s;
                    err_cnt_d = sat_add(err_cnt_q, e_s);
                    bit_cnt_d = sat_add(bit_cnt_q, 2'd2);
                    sym_err_d = (e_s != 2'd0);
                    if (win_err_sum_s >= WERR_W'(LOSS_THRESH)) begin
                        state_d    = ST_SEEK;
                        seek_cnt_d = '0;
                        win_cnt_d  = '0;
                        win_err_d  = '0;
                    end else if (win_cnt_q == WIN_W'(WINDOW_SYMS - 1)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_inc_s;
                        win_err_d = win_err_sum_s;
                    end
                end
                default: begin
                    state_d    = ST_SEEK;
                    seek_cnt_d = '0;
                end
            endcase
        end else begin
            sym_err_d = 1'b0;
        end

        // Clearing wins over an increment in the same cycle.
        if (clear_counts) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end else begin
            err_cnt_d = err_cnt_d;
            bit_cnt_d = bit_cnt_d;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SEEK;
            lfsr_q      <= '0;
            seek_cnt_q  <= '0;
            clean_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            locked_q    <= 1'b0;
            sym_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            seek_cnt_q  <= seek_cnt_d;
            clean_cnt_q <= clean_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            locked_q    <= locked_d;
            sym_err_q   <= sym_err_d;
        end
    end

    assign locked       = locked_q;
    assign error_count  = err_cnt_q;
    assign bit_count    = bit_cnt_q;
    assign symbol_error = sym_err_q;

endmodule

// File: tb/tb_pam_4_prbs_checker.sv
// Bench for pam_4_prbs_checker: PRBS7 stimulus with injected errors, checked against a
// bit-history reference model (b[n] = b[n-7] ^ b[n-6]) kept in the bench.
module tb_pam_4_prbs_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  symbol_in;
    logic        symbol_in_valid;
    logic        clear_counts;
    logic        locked, symbol_error;
    logic [31:0] error_count, bit_count;
    logic        locked4, symbol_error4;
    logic [3:0]  error_count4, bit_count4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pam_4_prbs_checker #(.PRBS_ORDER(7), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .symbol_in(symbol_in), .symbol_in_valid(symbol_in_valid),
        .clear_counts(clear_counts), .locked(locked), .error_count(error_count),
        .bit_count(bit_count), .symbol_error(symbol_error)
    );

    pam_4_prbs_checker #(.PRBS_ORDER(7), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .symbol_in(symbol_in), .symbol_in_valid(symbol_in_valid),
        .clear_counts(clear_counts), .locked(locked4), .error_count(error_count4),
        .bit_count(bit_count4), .symbol_error(symbol_error4)
    );

    // ---------------- stimulus source: PRBS7 transmitter ----------------
    logic [6:0] gen_q = 7'h7F;

    task automatic next_sym(output logic [1:0] sym);
        logic b1, b0;
        b1 = gen_q[6] ^ gen_q[5];
        gen_q = {gen_q[5:0], b1};
        b0 = gen_q[6] ^ gen_q[5];
        gen_q = {gen_q[5:0], b0};
        sym = {b1, b0};
    endtask

    // ---------------- reference model ----------------
    bit     hist[$];
    int     m_mode;          // 0 seek, 1 verify, 2 locked
    int     m_seek, m_clean, m_win_n, m_win_e;
    longint m_err, m_bits;
    bit     m_sym_err;

    task automatic model_reset();
        hist.delete();
        m_mode = 0; m_seek = 0; m_clean = 0; m_win_n = 0; m_win_e = 0;
        m_err = 0; m_bits = 0; m_sym_err = 1'b0;
    endtask

    function automatic bit last7_zero();
        bit z = 1'b1;
        for (int k = 0; k < 7; k++) if (hist[hist.size() - 1 - k]) z = 1'b0;
        return z;
    endfunction

    task automatic push_pred(output bit p);
        p = hist[hist.size() - 7] ^ hist[hist.size() - 6];
        hist.push_back(p);
    endtask

    task automatic model_edge(input logic v, input logic [1:0] sym, input logic clr);
        bit p1, p0;
        int e;
        m_sym_err = 1'b0;
        if (v) begin
            if (m_mode == 0) begin
                hist.push_back(sym[1]);
                hist.push_back(sym[0]);
                m_seek++;
                if (m_seek == 4) begin
                    m_seek = 0;
                    if (!last7_zero()) begin m_mode = 1; m_clean = 0; end
                end
            end else begin
                push_pred(p1);
                push_pred(p0);
                e = int'(p1 ^ sym[1]) + int'(p0 ^ sym[0]);
                if (m_mode == 1) begin
                    if (e != 0) begin
                        m_mode = 0; m_seek = 0;
                    end else begin
                        m_clean++;
                        if (m_clean == 16) begin m_mode = 2; m_win_n = 0; m_win_e = 0; end
                    end
                end else begin
                    m_err += e; m_bits += 2; m_sym_err = (e != 0);
                    m_win_e += e; m_win_n++;
                    if (m_win_e >= 8) begin m_mode = 0; m_seek = 0; end
                    else if (m_win_n == 64) begin m_win_n = 0; m_win_e = 0; end
                end
            end
            while (hist.size() > 16) void'(hist.pop_front());
        end
        if (clr) begin m_err = 0; m_bits = 0; end
    endtask

    // Drive one cycle at the falling edge, step the model at the rising edge, return 1 time unit later.
    task automatic drive(input logic v, input logic [1:0] sym, input logic clr);
        @(negedge clk);
        symbol_in_valid = v; symbol_in = sym; clear_counts = clr;
        @(posedge clk);
        model_edge(v, sym, clr);
        #1;
    endtask

    task automatic send_clean(input int n);
        logic [1:0] s;
        for (int i = 0; i < n; i++) begin next_sym(s); drive(1'b1, s, 1'b0); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; symbol_in_valid = 1'b0; symbol_in = 2'b00; clear_counts = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%0b exp=0", locked); end
        n_checks++; if (error_count !== 32'd0) begin n_fail++; $display("FAIL reset_err got=%0d exp=0", error_count); end
        n_checks++; if (bit_count !== 32'd0) begin n_fail++; $display("FAIL reset_bits got=%0d exp=0", bit_count); end
        n_checks++; if (symbol_error !== 1'b0) begin n_fail++; $display("FAIL reset_symerr got=%0b exp=0", symbol_error); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_acquire();
        logic [1:0] s;
        gen_q = 7'h7F;
        for (int i = 1; i <= 20; i++) begin
            next_sym(s); drive(1'b1, s, 1'b0);
            n_checks++;
            if (locked !== (i == 20)) begin n_fail++; $display("FAIL acquire_locked sym=%0d got=%0b exp=%0b", i, locked, (i == 20)); end
            n_checks++;
            if (bit_count !== 32'd0) begin n_fail++; $display("FAIL acquire_bits sym=%0d got=%0d exp=0", i, bit_count); end
        end
        send_clean(100);
        n_checks++; if (bit_count !== 32'd200) begin n_fail++; $display("FAIL acquire_bits100 got=%0d exp=200", bit_count); end
        n_checks++; if (error_count !== 32'd0) begin n_fail++; $display("FAIL acquire_err got=%0d exp=0", error_count); end
    endtask

    task automatic test_single_errors();
        logic [1:0] s;
        next_sym(s); drive(1'b1, s ^ 2'b01, 1'b0);
        n_checks++; if (error_count !== 32'd1) begin n_fail++; $display("FAIL single_err got=%0d exp=1", error_count); end
        n_checks++; if (symbol_error !== 1'b1) begin n_fail++; $display("FAIL single_pulse got=%0b exp=1", symbol_error); end
        send_clean(1);
        n_checks++; if (symbol_error !== 1'b0) begin n_fail++; $display("FAIL single_pulse_end got=%0b exp=0", symbol_error); end
        send_clean(5);
        next_sym(s); drive(1'b1, s ^ 2'b11, 1'b0);
        n_checks++; if (error_count !== 32'd3) begin n_fail++; $display("FAIL double_err got=%0d exp=3", error_count); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL double_locked got=%0b exp=1", locked); end
    endtask

    task automatic test_loss_of_lock();
        logic [1:0] s;
        next_sym(s); drive(1'b1, s, 1'b1);
        send_clean(64);
        for (int k = 0; k < 64 && m_win_n > 60; k++) send_clean(1);
        for (int i = 1; i <= 4; i++) begin
            next_sym(s); drive(1'b1, ~s, 1'b0);
            n_checks++;
            if (locked !== (i < 4)) begin n_fail++; $display("FAIL loss_locked sym=%0d got=%0b exp=%0b", i, locked, (i < 4)); end
        end
        n_checks++; if (error_count !== 32'd8) begin n_fail++; $display("FAIL loss_err got=%0d exp=8", error_count); end
        for (int i = 1; i <= 20; i++) begin
            next_sym(s); drive(1'b1, s, 1'b0);
            n_checks++;
            if (locked !== (i == 20)) begin n_fail++; $display("FAIL relock sym=%0d got=%0b exp=%0b", i, locked, (i == 20)); end
        end
    endtask

    task automatic test_zero_and_verify_error();
        logic [1:0] s;
        @(negedge clk); rst = 1'b1; symbol_in_valid = 1'b0; clear_counts = 1'b0;
        model_reset();
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, 2'b00, 1'b0);
            n_checks++;
            if (locked !== 1'b0) begin n_fail++; $display("FAIL zero_locked cyc=%0d got=%0b exp=0", i, locked); end
        end
        n_checks++;
        if (error_count !== 32'd0 || bit_count !== 32'd0) begin
            n_fail++; $display("FAIL zero_counts got=%0d/%0d exp=0/0", error_count, bit_count);
        end
        for (int i = 1; i <= 30; i++) begin
            next_sym(s);
            if (i == 10) s = s ^ 2'b10;
            drive(1'b1, s, 1'b0);
            n_checks++;
            if (locked !== (i == 30)) begin n_fail++; $display("FAIL verify_err_locked sym=%0d got=%0b exp=%0b", i, locked, (i == 30)); end
        end
    endtask

    task automatic test_valid_toggle();
        logic [1:0] s;
        int nvalid = 0;
        next_sym(s); drive(1'b1, s, 1'b1);
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                next_sym(s); drive(1'b1, s, 1'b0); nvalid++;
            end else begin
                drive(1'b0, 2'($urandom), 1'b0);
            end
            n_checks++;
            if (symbol_error !== 1'b0) begin n_fail++; $display("FAIL toggle_symerr cyc=%0d got=%0b exp=0", i, symbol_error); end
        end
        n_checks++; if (bit_count !== 32'(2 * nvalid)) begin n_fail++; $display("FAIL toggle_bits got=%0d exp=%0d", bit_count, 2 * nvalid); end
        n_checks++; if (error_count !== 32'd0) begin n_fail++; $display("FAIL toggle_err got=%0d exp=0", error_count); end
        next_sym(s); drive(1'b1, s ^ 2'b11, 1'b1);
        n_checks++;
        if (error_count !== 32'd0 || bit_count !== 32'd0) begin
            n_fail++; $display("FAIL clear_prio got=%0d/%0d exp=0/0", error_count, bit_count);
        end
        n_checks++; if (symbol_error !== 1'b1) begin n_fail++; $display("FAIL clear_symerr got=%0b exp=1", symbol_error); end
    endtask

    task automatic test_random();
        logic [1:0] s;
        logic       v, clr;
        int         burst = 0;
        logic [3:0] e4, b4;
        for (int i = 0; i < 1500; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 99) == 0);
            if (v) begin
                next_sym(s);
                if (burst == 0 && $urandom_range(0, 299) == 0) burst = 4;
                if (burst > 0) begin s = ~s; burst--; end
                else if ($urandom_range(0, 19) == 0) s = s ^ 2'($urandom_range(1, 3));
            end else begin
                s = 2'($urandom);
            end
            drive(v, s, clr);
            e4 = (m_err > 15) ? 4'd15 : 4'(m_err);
            b4 = (m_bits > 15) ? 4'd15 : 4'(m_bits);
            n_checks++;
            if (locked !== (m_mode == 2)) begin n_fail++; $display("FAIL rnd_locked cyc=%0d got=%0b exp=%0b", i, locked, (m_mode == 2)); end
            n_checks++;
            if (error_count !== 32'(m_err)) begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%0d exp=%0d", i, error_count, m_err); end
            n_checks++;
            if (bit_count !== 32'(m_bits)) begin n_fail++; $display("FAIL rnd_bits cyc=%0d got=%0d exp=%0d", i, bit_count, m_bits); end
            n_checks++;
            if (symbol_error !== m_sym_err) begin n_fail++; $display("FAIL rnd_symerr cyc=%0d got=%0b exp=%0b", i, symbol_error, m_sym_err); end
            n_checks++;
            if (error_count4 !== e4 || bit_count4 !== b4) begin
                n_fail++; $display("FAIL rnd_sat4 cyc=%0d got=%0d/%0d exp=%0d/%0d", i, error_count4, bit_count4, e4, b4);
            end
        end
    endtask

    task automatic test_saturation();
        logic [1:0] s;
        for (int k = 0; k < 100 && m_mode != 2; k++) send_clean(1);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_prelock got=%0b exp=1", locked); end
        next_sym(s); drive(1'b1, s, 1'b1);
        for (int k = 0; k < 64 && m_win_n != 0; k++) send_clean(1);
        for (int i = 0; i < 200; i++) begin
            next_sym(s);
            if (i % 10 == 9) s = s ^ 2'b01;
            drive(1'b1, s, 1'b0);
        end
        n_checks++; if (error_count4 !== 4'd15) begin n_fail++; $display("FAIL sat_err4 got=%0d exp=15", error_count4); end
        n_checks++; if (bit_count4 !== 4'd15) begin n_fail++; $display("FAIL sat_bits4 got=%0d exp=15", bit_count4); end
        n_checks++; if (error_count !== 32'd20) begin n_fail++; $display("FAIL sat_err32 got=%0d exp=20", error_count); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_locked got=%0b exp=1", locked); end
    endtask

    task automatic test_reset_midlock();
        logic [1:0] s;
        next_sym(s); drive(1'b1, s ^ 2'b01, 1'b0);
        n_checks++; if (symbol_error !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got=%0b exp=1", symbol_error); end
        @(negedge clk);
        next_sym(s);
        symbol_in_valid = 1'b1; symbol_in = s ^ 2'b11; clear_counts = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL midrst_locked got=%0b exp=0", locked); end
        n_checks++;
        if (error_count !== 32'd0 || bit_count !== 32'd0) begin
            n_fail++; $display("FAIL midrst_counts got=%0d/%0d exp=0/0", error_count, bit_count);
        end
        n_checks++; if (symbol_error !== 1'b0) begin n_fail++; $display("FAIL midrst_symerr got=%0b exp=0", symbol_error); end
        n_checks++; if (error_count4 !== 4'd0) begin n_fail++; $display("FAIL midrst_err4 got=%0d exp=0", error_count4); end
        model_reset();
        @(negedge clk); symbol_in_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            next_sym(s); drive(1'b1, s, 1'b0);
            n_checks++;
            if (locked !== (i == 20)) begin n_fail++; $display("FAIL midrst_relock sym=%0d got=%0b exp=%0b", i, locked, (i == 20)); end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_single_errors();
        test_loss_of_lock();
        test_zero_and_verify_error();
        test_valid_toggle();
        test_random();
        test_saturation();
        test_reset_midlock();
        @(negedge clk); symbol_in_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
